// File: rtl/req_index_encoder.sv
// rtl/req_index_encoder.sv - collects request pulses and emits their indices round-robin over valid/ready
module req_index_encoder #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [N-1:0]  req,
    input  logic          ready,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  pending,
    output logic          ovf
);

    logic [N-1:0]  pending_q, pending_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  cand;
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW-1:0] sel;
    logic [N-1:0]  sel_mask;
    logic          load;
    logic          ovf_hit;

    always_comb begin
        cand = pending_q | req;
        // rot[i] is the candidate i positions after ptr; 3-bit sum wraps mod 8
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = cand[ptr_q + i[IW-1:0]];
        end
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i[IW-1:0];
            end
        end
        sel      = ptr_q + off;
        sel_mask = {{(N-1){1'b0}}, 1'b1} << sel;
        load     = !valid_q || ready;
    end

    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        ovf_hit   = 1'b0;
        if (load) begin
            if (|cand) begin
                pending_d = cand & ~sel_mask;
                valid_d   = 1'b1;
                idx_d     = sel;
                ptr_d     = sel + 1'b1;
                // a repeat of the bit being selected is consumed, not an overflow
                ovf_hit   = |(req & pending_q & ~sel_mask);
            end else begin
                pending_d = '0;
                valid_d   = 1'b0;
            end
        end else begin
            pending_d = cand;
            ovf_hit   = |(req & pending_q);
        end
        ovf_d = ovf_q || ovf_hit;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            ptr_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign valid   = valid_q;
    assign idx     = idx_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_req_index_encoder.sv
// tb/tb_req_index_encoder.sv - scoreboard bench for req_index_encoder with a behavioural model
module tb_req_index_encoder;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ready = 1'b0;
    logic       valid;
    logic [2:0] idx;
    logic [7:0] pending;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    req_index_encoder #(.N(8), .IW(3)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .ready   (ready),
        .valid   (valid),
        .idx     (idx),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // model: pending events as flags, plain integers for pointer and slot
    bit   m_p[8];
    bit   m_valid;
    int   m_idx;
    int   m_ptr;
    bit   m_ovf;
    int   idx_q[$];
    logic [12:0] snap_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_p[i] = 0;
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
        m_ovf   = 0;
        idx_q.delete();
        snap_q.delete();
    endtask

    task automatic model_step(input logic [7:0] r, input logic rd);
        bit         cand[8];
        int         sel;
        logic [7:0] pv;
        sel = -1;
        for (int i = 0; i < 8; i++) cand[i] = m_p[i] || r[i];
        if (!m_valid || rd) begin
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (sel < 0 && cand[j]) sel = j;
            end
            if (sel >= 0) begin
                for (int i = 0; i < 8; i++) begin
                    if (r[i] && m_p[i] && i != sel) m_ovf = 1;
                    m_p[i] = cand[i] && (i != sel);
                end
                m_idx   = sel;
                m_valid = 1;
                m_ptr   = (sel + 1) % 8;
                idx_q.push_back(sel);
            end else begin
                m_valid = 0;
                for (int i = 0; i < 8; i++) m_p[i] = 0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r[i] && m_p[i]) m_ovf = 1;
                m_p[i] = cand[i];
            end
        end
        for (int i = 0; i < 8; i++) pv[i] = m_p[i];
        snap_q.push_back({m_valid, m_ovf, pv, 3'(m_idx)});
    endtask

    task automatic apply(input logic [7:0] r, input logic rd);
        req   = r;
        ready = rd;
        model_step(r, rd);
    endtask

    task automatic cycle(input logic [7:0] r, input logic rd);
        @(negedge clk);
        apply(r, rd);
    endtask

    // monitor: one snapshot per active edge, one index per new presentation
    initial begin
        logic        prev_valid;
        logic [12:0] s;
        int          e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!clr) begin
                prev_valid = 1'b0;
            end else begin
                if (snap_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL snapshot_missing at %0t", $time);
                end else begin
                    s = snap_q.pop_front();
                    chk("valid", 32'(valid), 32'(s[12]));
                    chk("ovf", 32'(ovf), 32'(s[11]));
                    chk("pending", 32'(pending), 32'(s[10:3]));
                    if (s[12]) chk("idx_held", 32'(idx), 32'(s[2:0]));
                end
                if (valid && (!prev_valid || ready)) begin
                    if (idx_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_index at %0t: got %0d expected none", $time, idx);
                    end else begin
                        e = idx_q.pop_front();
                        chk("delivered_idx", 32'(idx), 32'(e));
                    end
                end
                prev_valid = valid;
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        apply(8'h00, 1'b0);

        // pulse with ready=1
        cycle(8'h85, 1'b1);
        cycle(8'h00, 1'b1);
        chk("pulse_idx0", 32'(idx), 32'd0);
        chk("pulse_pend84", 32'(pending), 32'h84);
        cycle(8'h00, 1'b1);
        chk("pulse_idx2", 32'(idx), 32'd2);
        chk("pulse_pend80", 32'(pending), 32'h80);
        cycle(8'h00, 1'b1);
        chk("pulse_idx7", 32'(idx), 32'd7);
        chk("pulse_pend00", 32'(pending), 32'h00);
        cycle(8'h00, 1'b1);
        chk("pulse_empty", 32'(valid), 32'd0);

        // round-robin wrap
        cycle(8'h81, 1'b1);
        cycle(8'h80, 1'b1);
        chk("wrap_idx0", 32'(idx), 32'd0);
        cycle(8'h00, 1'b1);
        chk("wrap_idx7", 32'(idx), 32'd7);
        chk("wrap_no_ovf", 32'(ovf), 32'd0);
        cycle(8'h00, 1'b1);
        chk("wrap_empty", 32'(valid), 32'd0);

        // backpressure
        cycle(8'h08, 1'b0);
        cycle(8'h30, 1'b0);
        chk("bp_idx3", 32'(idx), 32'd3);
        cycle(8'h00, 1'b0);
        chk("bp_hold_idx", 32'(idx), 32'd3);
        chk("bp_hold_valid", 32'(valid), 32'd1);
        chk("bp_pend30", 32'(pending), 32'h30);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        chk("bp_idx4", 32'(idx), 32'd4);
        cycle(8'h00, 1'b1);
        chk("bp_idx5", 32'(idx), 32'd5);
        cycle(8'h00, 1'b1);

        // same-bit re-request while idx=6 is held
        cycle(8'h40, 1'b1);
        cycle(8'h40, 1'b0);
        chk("same_idx6", 32'(idx), 32'd6);
        cycle(8'h00, 1'b0);
        chk("same_pend40", 32'(pending), 32'h40);
        chk("same_no_ovf", 32'(ovf), 32'd0);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        chk("same_idx6_again", 32'(idx), 32'd6);
        chk("same_valid", 32'(valid), 32'd1);
        cycle(8'h00, 1'b1);

        // overflow/merge: hold idx=1 with pending=04, re-pulse bit 2
        cycle(8'h06, 1'b0);
        cycle(8'h04, 1'b0);
        chk("ovf_idx1", 32'(idx), 32'd1);
        chk("ovf_pend04", 32'(pending), 32'h04);
        cycle(8'h00, 1'b1);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_pend_once", 32'(pending), 32'h04);
        cycle(8'h00, 1'b1);
        chk("ovf_idx2", 32'(idx), 32'd2);
        cycle(8'h00, 1'b1);
        chk("ovf_single_emit", 32'(valid), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
            cycle(r, $urandom_range(0, 3) != 0);
        end

        // asynchronous reset mid-stream
        for (int n = 0; n < 10; n++) cycle(8'h00, 1'b1);
        cycle(8'h01, 1'b1);
        cycle(8'hF0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_pend", 32'(pending), 32'hF0);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        #1;
        clr = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_idx", 32'(idx), 32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        model_reset();
        req   = 8'h00;
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        apply(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        chk("post_rst_empty", 32'(valid), 32'd0);
        cycle(8'h00, 1'b1);
        chk("post_rst_empty2", 32'(valid), 32'd0);

        for (int n = 0; n < 500; n++) begin
            cycle(8'($urandom_range(0, 255) & $urandom_range(0, 255)), $urandom_range(0, 1) != 0);
        end
        for (int n = 0; n < 12; n++) cycle(8'h00, 1'b1);
        @(posedge clk);
        #2;
        chk("idx_queue_drained", 32'(idx_q.size()), 32'd0);
        chk("snap_queue_drained", 32'(snap_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
